// File: rtl/traveler_uart_tx_scheduler.sv
// traveler_uart_tx_scheduler
//   Shares one UART transmitter between two command sources (operation byte
//   and target-select byte). A value change on a source (other than
//   IGNORE_CODE) becomes a pending one-byte frame. Pending frames are sent
//   under round-robin arbitration with a start/busy handshake, a busy-rise
//   timeout and a minimum inter-frame gap.
//
//   Optional feature: define TRAVELER_TX_HEARTBEAT_EN to send HB_BYTE after
//   HB_PERIOD idle cycles with nothing pending.
//
// Ports
//   uart_clk      sole clock, rising edge
//   rst_n         asynchronous active-low reset
//   op_data       operation byte (uart_clk domain)
//   sel_data      target-select byte (uart_clk domain)
//   tx_busy       UART TX busy, high from accepted start until stop bit ends
//   tx_start      one-cycle start pulse to the UART TX
//   tx_data       frame byte, stable from tx_start until the next grant
//   drop_cnt      saturating count of pending frames overwritten unsent
//   timeout_flag  sticky, set when tx_busy fails to rise in BUSY_TIMEOUT
module traveler_uart_tx_scheduler #(
  parameter logic [7:0]  IGNORE_CODE  = 8'h00,
  parameter int unsigned GAP_CYCLES   = 16,
  parameter int unsigned BUSY_TIMEOUT = 1024,
  parameter int unsigned HB_PERIOD    = 1_000_000,
  parameter logic [7:0]  HB_BYTE      = 8'hFF
) (
  input  logic       uart_clk,
  input  logic       rst_n,
  input  logic [7:0] op_data,
  input  logic [7:0] sel_data,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [7:0] drop_cnt,
  output logic       timeout_flag
);

  // Source index: 0 = OP, 1 = SEL.
  localparam logic SRC_OP  = 1'b0;
  localparam logic SRC_SEL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t          r_state;
  logic [1:0][7:0] r_last;
  logic [1:0][7:0] r_slot;
  logic [1:0]      r_pend;
  logic            r_last_grant;
  logic [31:0]     r_cnt;
  logic [7:0]      r_drop;
  logic            r_timeout;
  logic            r_tx_start;
  logic [7:0]      r_tx_data;

  logic [1:0][7:0] w_src;
  logic [1:0]      w_chg;
  logic [1:0]      w_clr;
  logic [1:0]      w_drop;
  logic            w_idle;
  logic            w_grant_op;
  logic            w_grant_sel;
  logic [8:0]      w_drop_sum;
  logic            w_hb_fire;

  assign w_src  = {sel_data, op_data};
  assign w_idle = (r_state == S_IDLE);

  // Round robin: on a tie the source that was not granted last wins.
  assign w_grant_op  = w_idle && r_pend[0] && (!r_pend[1] || (r_last_grant == SRC_SEL));
  assign w_grant_sel = w_idle && r_pend[1] && (!r_pend[0] || (r_last_grant == SRC_OP));
  assign w_clr       = {w_grant_sel, w_grant_op};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_chg[i]  = (w_src[i] != r_last[i]) && (w_src[i] != IGNORE_CODE);
      // A slot granted this cycle is being emptied, so a new value is not a drop.
      w_drop[i] = w_chg[i] && r_pend[i] && !w_clr[i];
    end
  end

  assign w_drop_sum = {1'b0, r_drop} + {8'b0, w_drop[0]} + {8'b0, w_drop[1]};

  // Change detect and pending slots. A new change outranks a same-cycle grant
  // clear, so the slot keeps the newer value pending.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= {IGNORE_CODE, IGNORE_CODE};
      r_slot <= {IGNORE_CODE, IGNORE_CODE};
      r_pend <= 2'b00;
      r_drop <= 8'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_last[i] <= w_src[i];
        if (w_chg[i]) begin
          r_slot[i] <= w_src[i];
          r_pend[i] <= 1'b1;
        end else if (w_clr[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
      r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

`ifdef TRAVELER_TX_HEARTBEAT_EN
  logic [31:0] r_hb_cnt;

  assign w_hb_fire = w_idle && (r_pend == 2'b00) && (r_hb_cnt == HB_PERIOD - 1);

  // Counts only idle cycles with nothing pending; any grant or heartbeat
  // leaves IDLE (or empties it), which clears the count.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hb_cnt <= 32'd0;
    end else if (w_idle && (r_pend == 2'b00) && !w_hb_fire) begin
      r_hb_cnt <= r_hb_cnt + 32'd1;
    end else begin
      r_hb_cnt <= 32'd0;
    end
  end
`else
  logic w_unused_hb;
  assign w_unused_hb = ^{HB_BYTE, HB_PERIOD};
  assign w_hb_fire   = 1'b0;
`endif

  // Transmit FSM. r_cnt is shared: busy-rise timeout in WAIT_BUSY, gap in GAP.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= SRC_SEL;
      r_cnt        <= 32'd0;
      r_timeout    <= 1'b0;
      r_tx_start   <= 1'b0;
      r_tx_data    <= IGNORE_CODE;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_op) begin
            r_tx_data    <= r_slot[0];
            r_last_grant <= SRC_OP;
            r_tx_start   <= 1'b1;
            r_state      <= S_START;
          end else if (w_grant_sel) begin
            r_tx_data    <= r_slot[1];
            r_last_grant <= SRC_SEL;
            r_tx_start   <= 1'b1;
            r_state      <= S_START;
          end else if (w_hb_fire) begin
            r_tx_data  <= HB_BYTE;
            r_tx_start <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= 32'd0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_cnt == BUSY_TIMEOUT - 1) begin
            // Frame abandoned; still honour the gap before the next one.
            r_timeout <= 1'b1;
            r_cnt     <= 32'd0;
            r_state   <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            r_cnt   <= 32'd0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_CYCLES - 1) begin
            r_cnt   <= 32'd0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_start     = r_tx_start;
  assign tx_data      = r_tx_data;
  assign drop_cnt     = r_drop;
  assign timeout_flag = r_timeout;

endmodule

// File: tb/tb_traveler_uart_tx_scheduler.sv
// Self-checking bench for traveler_uart_tx_scheduler: a table of same-edge
// source changes with the expected frame order, plus hand-written sequences
// for timing, overwrite/drop, ignore code, timeout, reset and heartbeat.
module tb_traveler_uart_tx_scheduler;

  localparam int GAP = 16;
  localparam int BT  = 1024;

  logic       uart_clk = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] op_data  = 8'h00;
  logic [7:0] sel_data = 8'h00;
  logic       tx_busy  = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [7:0] drop_cnt;
  logic       timeout_flag;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Busy model controls
  bit model_on  = 1'b1;
  int busy_len  = 10;
  int busy_left = 0;
  int fall_cyc  = 0;

  int         st_cyc[$];
  logic [7:0] st_dat[$];

  traveler_uart_tx_scheduler #(
    .IGNORE_CODE (8'h00),
    .GAP_CYCLES  (GAP),
    .BUSY_TIMEOUT(BT)
  ) dut (
    .uart_clk    (uart_clk),
    .rst_n       (rst_n),
    .op_data     (op_data),
    .sel_data    (sel_data),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .drop_cnt    (drop_cnt),
    .timeout_flag(timeout_flag)
  );

  always #5 uart_clk = ~uart_clk;

  always @(posedge uart_clk) cyc <= cyc + 1;

  // UART TX stand-in: busy rises in the start cycle, holds busy_len cycles.
  always @(negedge uart_clk) begin
    if (!rst_n) begin
      tx_busy   = 1'b0;
      busy_left = 0;
    end else begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          tx_busy  = 1'b0;
          fall_cyc = cyc + 1;  // first edge that samples busy low
        end
      end
      if (tx_start && model_on) begin
        tx_busy   = 1'b1;
        busy_left = busy_len;
      end
    end
  end

  always @(negedge uart_clk) begin
    if (rst_n && tx_start) begin
      st_cyc.push_back(cyc);
      st_dat.push_back(tx_data);
    end
  end

`ifdef TRAVELER_TX_HEARTBEAT_EN
  logic       hb_rst_n = 1'b0;
  logic [7:0] hb_op    = 8'h00;
  logic [7:0] hb_sel   = 8'h00;
  logic       hb_busy  = 1'b0;
  logic       hb_start;
  logic [7:0] hb_data;
  logic [7:0] hb_drop;
  logic       hb_to;
  int         hb_left  = 0;
  int         hb_cyc[$];
  logic [7:0] hb_dat[$];

  traveler_uart_tx_scheduler #(
    .GAP_CYCLES(GAP),
    .HB_PERIOD (50),
    .HB_BYTE   (8'hFF)
  ) dut_hb (
    .uart_clk    (uart_clk),
    .rst_n       (hb_rst_n),
    .op_data     (hb_op),
    .sel_data    (hb_sel),
    .tx_busy     (hb_busy),
    .tx_start    (hb_start),
    .tx_data     (hb_data),
    .drop_cnt    (hb_drop),
    .timeout_flag(hb_to)
  );

  always @(negedge uart_clk) begin
    if (!hb_rst_n) begin
      hb_busy = 1'b0;
      hb_left = 0;
    end else begin
      if (hb_left > 0) begin
        hb_left--;
        if (hb_left == 0) hb_busy = 1'b0;
      end
      if (hb_start) begin
        hb_busy = 1'b1;
        hb_left = 10;
        hb_cyc.push_back(cyc);
        hb_dat.push_back(hb_data);
      end
    end
  end
`endif

  typedef struct {
    logic [7:0] op;
    logic [7:0] sel;
    int         nexp;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  vec_t vec[6];

  task automatic step();
    @(negedge uart_clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    int k = 0;
    while (st_dat.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(tag, st_dat.size(), n);
  endtask

  task automatic do_reset();
    step();
    rst_n    = 1'b0;
    op_data  = 8'h00;
    sel_data = 8'h00;
    model_on = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    st_cyc.delete();
    st_dat.delete();
    step();
  endtask

  initial begin
    int c0, base, s;

    // ---------------- reset state ----------------
    #1;
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_timeout", timeout_flag, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // ---------------- table: same-edge changes, round robin ----------------
    // last_grant starts at SEL, so OP wins the first tie.
    vec[0] = '{op: 8'h03, sel: 8'h21, nexp: 2, e0: 8'h03, e1: 8'h21};
    vec[1] = '{op: 8'h0A, sel: 8'h22, nexp: 2, e0: 8'h0A, e1: 8'h22};
    vec[2] = '{op: 8'h00, sel: 8'h23, nexp: 1, e0: 8'h23, e1: 8'h00};  // op to ignore
    vec[3] = '{op: 8'h0B, sel: 8'h23, nexp: 1, e0: 8'h0B, e1: 8'h00};  // last_grant=OP now
    vec[4] = '{op: 8'h0C, sel: 8'h24, nexp: 2, e0: 8'h24, e1: 8'h0C};  // tie -> SEL first
    vec[5] = '{op: 8'h0C, sel: 8'h24, nexp: 0, e0: 8'h00, e1: 8'h00};  // no change
    busy_len = 10;
    for (int i = 0; i < 6; i++) begin
      base     = st_dat.size();
      op_data  = vec[i].op;
      sel_data = vec[i].sel;
      repeat (100) step();
      chk($sformatf("vec%0d_count", i), st_dat.size() - base, vec[i].nexp);
      if (vec[i].nexp > 0 && st_dat.size() > base)
        chk($sformatf("vec%0d_b0", i), st_dat[base], vec[i].e0);
      if (vec[i].nexp > 1 && st_dat.size() > base + 1)
        chk($sformatf("vec%0d_b1", i), st_dat[base+1], vec[i].e1);
    end
    chk("vec_drop", drop_cnt, 0);

    // ---------------- latency and gap ----------------
    do_reset();
    busy_len = 100;
    c0 = cyc;
    op_data = 8'h05;
    repeat (20) step();
    chk("lat_count", st_dat.size(), 1);
    if (st_dat.size() > 0) begin
      chk("lat_cycles", st_cyc[0] - c0, 2);
      chk("lat_data", st_dat[0], 8'h05);
    end
    op_data = 8'h07;  // pending behind the busy frame
    wait_starts(2, 300, "gap_wait");
    if (st_dat.size() > 1) begin
      // busy low sampled at edge D -> 16 GAP cycles -> IDLE grant at D+17
      chk("gap_cycles", st_cyc[1] - fall_cyc, GAP + 1);
      chk("gap_data", st_dat[1], 8'h07);
    end

    // ---------------- set/clear collision ----------------
    do_reset();
    busy_len = 10;
    op_data = 8'h11;
    step();
    op_data = 8'h12;  // latched on the very edge that grants 0x11
    wait_starts(2, 200, "coll_wait");
    if (st_dat.size() > 1) begin
      chk("coll_b0", st_dat[0], 8'h11);
      chk("coll_b1", st_dat[1], 8'h12);
    end
    chk("coll_drop", drop_cnt, 0);

    // ---------------- overwrite while busy ----------------
    do_reset();
    busy_len = 100;
    sel_data = 8'h30;
    wait_starts(1, 50, "ovw_first");
    repeat (5) step();
    op_data = 8'h01; step();
    op_data = 8'h02; step();
    op_data = 8'h04; step();
    chk("ovw_drop", drop_cnt, 2);
    repeat (300) step();
    chk("ovw_count", st_dat.size(), 2);
    if (st_dat.size() > 1) chk("ovw_data", st_dat[1], 8'h04);

    // drop_cnt saturates at 255
    busy_len = 600;
    sel_data = 8'h31;
    wait_starts(3, 200, "sat_first");
    for (int i = 0; i < 300; i++) begin
      op_data = i[0] ? 8'h42 : 8'h41;
      step();
    end
    chk("sat_drop", drop_cnt, 255);
    repeat (700) step();

    // ---------------- ignore code / re-presented value ----------------
    do_reset();
    busy_len = 10;
    op_data = 8'h05;
    wait_starts(1, 50, "ign_first");
    repeat (40) step();
    op_data = 8'h00;
    repeat (1000) step();
    chk("ign_none", st_dat.size(), 1);
    op_data = 8'h05;
    wait_starts(2, 100, "ign_again");
    if (st_dat.size() > 1) chk("ign_data", st_dat[1], 8'h05);

    // ---------------- busy timeout ----------------
    do_reset();
    model_on = 1'b0;
    op_data  = 8'h55;
    wait_starts(1, 50, "to_first");
    s = (st_cyc.size() > 0) ? st_cyc[0] : cyc;
    sel_data = 8'h66;
    model_on = 1'b1;
    busy_len = 10;
    while (cyc < s + BT) step();
    chk("to_before", timeout_flag, 0);
    step();
    chk("to_after", timeout_flag, 1);
    wait_starts(2, 100, "to_next");
    if (st_dat.size() > 1) begin
      chk("to_next_cyc", st_cyc[1] - s, BT + GAP + 2);
      chk("to_next_data", st_dat[1], 8'h66);
    end
    chk("to_sticky", timeout_flag, 1);

    // ---------------- reset mid-frame ----------------
    do_reset();
    busy_len = 100;
    op_data  = 8'h21;
    wait_starts(1, 50, "rmf_first");
    repeat (5) step();
    op_data = 8'h22; step();
    op_data = 8'h23; step();
    chk("rmf_pre_drop", drop_cnt, 1);
    rst_n = 1'b0;
    #1;
    chk("rmf_tx_start", tx_start, 0);
    chk("rmf_tx_data", tx_data, 8'h00);
    chk("rmf_drop", drop_cnt, 0);
    chk("rmf_timeout", timeout_flag, 0);
    op_data = 8'h00;
    step();
    rst_n = 1'b1;
    st_cyc.delete();
    st_dat.delete();
    repeat (300) step();
    chk("idle_quiet", st_dat.size(), 0);

`ifdef TRAVELER_TX_HEARTBEAT_EN
    // ---------------- heartbeat ----------------
    hb_rst_n = 1'b1;
    repeat (200) step();
    chk("hb_count", (hb_dat.size() >= 2) ? 1 : 0, 1);
    if (hb_dat.size() >= 2) begin
      chk("hb_data0", hb_dat[0], 8'hFF);
      chk("hb_data1", hb_dat[1], 8'hFF);
      // 50 idle + start/wait/10 busy/16 gap
      chk("hb_period", hb_cyc[1] - hb_cyc[0], 77);
    end
    chk("hb_drop", hb_drop, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
